// File: rtl/led_pkg.sv
// Shared types and constants for the LED decoder/scan block and its 7-seg lookup.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STATIC = 2'd1,
        SCAN   = 2'd2
    } led_state_t;

    // Active-low segment patterns, bit order g..a.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;

endpackage

// File: rtl/seg_digit_lut.sv
// Combinational 3-bit index to active-low 7-segment digit pattern.
module seg_digit_lut
    import led_pkg::*;
(
    input  logic [2:0] idx_i,
    output logic [6:0] seg_o
);

    // Table lookup of the digit glyph for the current index.
    always_comb begin
        seg_o = SEG_BLANK;
        case (idx_i)
            3'd0: seg_o = SEG_0;
            3'd1: seg_o = SEG_1;
            3'd2: seg_o = SEG_2;
            3'd3: seg_o = SEG_3;
            3'd4: seg_o = SEG_4;
            3'd5: seg_o = SEG_5;
            3'd6: seg_o = SEG_6;
            3'd7: seg_o = SEG_7;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led_decoder_scan.sv
// One-hot LED driver: shows a selected LED (STATIC) or walks it around the
// bank every TICK_DIV cycles (SCAN). The 7-seg digit shows the lit index.
// Outputs depend on registered state only, so every input sampled at an edge
// becomes visible right after that edge and never combinationally.
module led_decoder_scan
    import led_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = $clog2(TICK_DIV) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] code,
    output logic [7:0] led,
    output logic       active,
    output logic [6:0] seg
);

    led_state_t       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_due;
    logic [6:0]       digit;

    assign step_due = (cnt_q == CNT_W'(TICK_DIV - 1));

    // State, index and dwell counter registers with immediate async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. Priority: enable low > load > mode change > scan step.
    // Leaving via enable=0 keeps idx/cnt; re-entry reloads them anyway.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // load is irrelevant here: code is always taken on entry.
                    idx_d   = code;
                    cnt_d   = '0;
                    state_d = mode ? SCAN : STATIC;
                end
                STATIC: begin
                    if (load) begin
                        idx_d = code;
                    end
                    if (mode) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        // Freeze where we are; a coincident step is dropped.
                        state_d = STATIC;
                        if (load) begin
                            idx_d = code;
                        end
                    end else if (load) begin
                        idx_d = code;
                        cnt_d = '0;
                    end else if (step_due) begin
                        cnt_d = '0;
                        idx_d = dir ? (idx_q - 3'd1) : (idx_q + 3'd1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    seg_digit_lut u_lut (
        .idx_i (idx_q),
        .seg_o (digit)
    );

    // Output decode from registered state: dark and blank while idle.
    always_comb begin
        led    = 8'h00;
        active = 1'b0;
        seg    = SEG_BLANK;
        if (state_q != IDLE) begin
            led    = 8'(1) << idx_q;
            active = 1'b1;
            seg    = digit;
        end
    end

endmodule

// File: doc/led_decoder_scan.md
Name: led_decoder_scan

Overview:
Drives the 8-LED bank with a one-hot pattern. It is the decoder-direction counterpart of the switch-bank priority-encoder path, and sits between the control switches and the LED bank / 7-segment digit.
- STATIC mode: shows one selected LED.
- SCAN mode: walks the lit LED around the bank at a programmable rate.
- The 7-segment digit shows the current LED index.

Parameters:
- TICK_DIV, 4, cycles per scan step (≥1; board builds override with a large value).
- CNT_W, $clog2(TICK_DIV)+1, width of the scan-step counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block enable; low forces IDLE.
- mode  input  1  0 = STATIC, 1 = SCAN.
- dir  input  1  scan direction: 0 = index up, 1 = index down.
- load  input  1  single-cycle pulse; latch `code` into the index.
- code  input  3  LED index to load or start from.
- led  output  8  one-hot LED pattern; bit idx set.
- active  output  1  high when any LED is lit.
- seg  output  7  active-low 7-seg pattern of idx (bit order g..a).

Behaviour:
- Registers:
  - `state` ∈ {IDLE, STATIC, SCAN}.
  - `idx` [2:0].
  - `cnt` [CNT_W-1:0].
- Reset (async, immediate, no clock needed):
  - state=IDLE, idx=0, cnt=0.
  - Outputs: led=8'h00, active=0, seg=7'b1111111.
- Outputs are combinational functions of registered state only; no input feeds an output directly.
  - IDLE: led=0, active=0, seg=blank.
  - Otherwise: led = 8'b1 << idx, active=1, seg = digit(idx).
- Latency: an input sampled at edge N is visible on the outputs right after edge N.
- enable=0 in any state → IDLE at next edge; idx and cnt are held, not cleared.
- IDLE, enable=1 → idx<=code, cnt<=0, state<= mode ? SCAN : STATIC. `load` is ignored in IDLE.
- STATIC:
  - load=1 → idx<=code.
  - mode=1 → SCAN with cnt<=0.
  - Both in the same cycle → both apply.
  - A change on `code` without `load` has no effect.
- SCAN:
  - Each cycle: cnt<=cnt+1.
  - When cnt==TICK_DIV-1: cnt<=0 and idx<=idx+1 (dir=0) or idx-1 (dir=1), modulo 8. Wrap is 7→0 going up, 0→7 going down.
  - TICK_DIV=1: idx steps every cycle.
  - load=1 → idx<=code, cnt<=0. Load has priority over a coincident step.
  - mode=0 → STATIC, idx frozen. A coincident step is discarded; a coincident load is applied.
  - A change on `dir` takes effect at the next step.
- Priority per edge: rst > enable=0 > load > mode change > scan step.
- Digit table (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
- Invariant: `led` is always exactly one-hot or zero. Feeding `led` into the high-priority encoder returns idx, and its indicator equals `active`.

Decomposition:
- Shared package `led_pkg`:
  - state enum `led_state_t` {IDLE, STATIC, SCAN}.
  - constant SEG_BLANK = 7'b1111111.
  - the eight active-low digit constants SEG_0..SEG_7.
- One sub-module `seg_digit_lut`: 3-bit index → 7-bit active-low pattern using the package constants, purely combinational.
- FSM, counter and one-hot decode stay in `led_decoder_scan`.

Test Plan:
1. Reset stability: assert rst with no clock running → led=00, active=0, seg=1111111. Release rst with enable=0 and clock 5 cycles → outputs unchanged.
2. STATIC entry: enable=1, mode=0, code=5 → after one edge led=8'h20, active=1, seg=0010010. Then change code to 3 with no load → led stays 8'h20.
3. STATIC load: load pulse with code=2 → led=8'h04, seg=0100100 after the edge. Next, drive enable=0 → led=0, seg blank after one edge. Re-enable with code=7 → led=8'h80.
4. SCAN up with TICK_DIV=4, dir=0, start code=6 → led=8'h40 for 4 cycles, then 8'h80 for 4 cycles, then 8'h01 (wrap 7→0).
5. SCAN down and collisions: dir=1 from idx=0 → next step gives led=8'h80 (wrap 0→7). Load code=4 on the exact step cycle → led=8'h10 and the next step occurs 4 cycles later. mode=0 on a step cycle → idx frozen.
6. Reset mid-scan: assert rst asynchronously between edges while in SCAN at idx=3 → outputs go to 0/blank immediately. After release with enable=1, mode=1, code=1 → scan restarts from led=8'h02 with a full TICK_DIV dwell.
